sdram_req_arbiter: RTL



---
 rtl/sdram_req_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_req_arbiter
// Description : N-channel request arbiter in front of the sdrc_core app port
//               (fixed priority ch0, round-robin rest, read owner-tag FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_req_arbiter #(
    parameter int NCH   = 4,
    parameter int AW    = 25,
    parameter int DW    = 16,
    parameter int LENW  = 9,
    parameter int TAGD  = 4,
    parameter int GUARD = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH-1:0]      ch_req,
    input  logic [NCH-1:0]      ch_wr_n,
    input  logic [NCH*AW-1:0]   ch_addr,
    input  logic [NCH*LENW-1:0] ch_len,
    input  logic [NCH*DW-1:0]   ch_wdata,
    output logic [NCH-1:0]      ch_ack,
    output logic [NCH-1:0]      ch_wr_next,
    output logic [NCH-1:0]      ch_rd_valid,
    output logic [NCH-1:0]      ch_rd_last,
    output logic [DW-1:0]       rd_data,
    output logic                app_req,
    output logic [AW-1:0]       app_req_addr,
    output logic [LENW-1:0]     app_req_len,
    output logic                app_req_wr_n,
    output logic                app_req_dma_last,
    output logic [DW-1:0]       app_wr_data,
    input  logic                app_req_ack,
    input  logic                app_wr_next_req,
    input  logic                app_last_wr,
    input  logic                app_rd_valid,
    input  logic                app_last_rd,
    input  logic [DW-1:0]       app_rd_data,
    output logic                busy,
    output logic                err_orphan_rd
);

    localparam int c_OW = $clog2(NCH);
    localparam int c_PW = (TAGD > 1) ? $clog2(TAGD) : 1;
    localparam int c_CW = $clog2(TAGD + 1);
    localparam int c_GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_OW-1:0]   r_owner;
    logic [AW-1:0]     r_addr;
    logic [LENW-1:0]   r_len;
    logic              r_wr_n;
    logic [c_OW-1:0]   r_rr_ptr;
    logic [c_OW-1:0]   r_tag [TAGD];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_CW-1:0]   r_count;
    logic [c_GW-1:0]   r_guard;
    logic              r_err;

    logic [AW-1:0]     w_addr_a  [NCH];
    logic [LENW-1:0]   w_len_a   [NCH];
    logic [DW-1:0]     w_wdata_a [NCH];
    logic [NCH-1:0]    w_elig;
    logic              w_found;
    logic [c_OW-1:0]   w_win;
    logic [c_OW-1:0]   w_cand;
    logic [LENW-1:0]   w_len_sel;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_orphan;
    logic [c_OW-1:0]   w_head;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_CW'(TAGD));
    assign w_head   = r_tag[r_rptr];
    assign w_push   = (r_state == ST_REQ) && app_req_ack && r_wr_n;
    assign w_pop    = app_rd_valid && app_last_rd && !w_empty;
    assign w_orphan = app_rd_valid && w_empty;

    // Writes must wait for an empty tag FIFO and a quiet read-return bus
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            assign w_addr_a[i]  = ch_addr[i*AW +: AW];
            assign w_len_a[i]   = ch_len[i*LENW +: LENW];
            assign w_wdata_a[i] = ch_wdata[i*DW +: DW];
            assign w_elig[i]    = ch_req[i] &&
                                  (ch_wr_n[i] ? !w_full
                                              : (w_empty && (r_guard == '0) && !app_rd_valid));
        end
    endgenerate

    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        if (w_elig[0]) begin
            w_found = 1'b1;
        end else begin
            for (int off = 0; off < NCH - 1; off++) begin
                idx    = ((int'(r_rr_ptr) - 1 + off) % (NCH - 1)) + 1;
                w_cand = c_OW'(idx);
                if (!w_found && w_elig[w_cand]) begin
                    w_found = 1'b1;
                    w_win   = w_cand;
                end
            end
        end
    end

    assign w_len_sel = w_len_a[w_win];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_state_nxt = ST_REQ;
            ST_REQ:   if (app_req_ack) w_state_nxt = r_wr_n ? ST_IDLE : ST_WDATA;
            ST_WDATA: if (app_last_wr) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_wr_n   <= 1'b0;
            r_rr_ptr <= c_OW'(1);
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_found) begin
                r_owner <= w_win;
                r_addr  <= w_addr_a[w_win];
                r_len   <= (w_len_sel == '0) ? LENW'(1) : w_len_sel;
                r_wr_n  <= ch_wr_n[w_win];
                if (w_win != '0) begin
                    r_rr_ptr <= (w_win == c_OW'(NCH - 1)) ? c_OW'(1) : w_win + c_OW'(1);
                end
            end
        end
    end

    // Owner-tag FIFO: one entry per accepted read, popped on its last beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < TAGD; i++) r_tag[i] <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= r_owner;
                r_wptr <= (r_wptr == c_PW'(TAGD - 1)) ? '0 : r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PW'(TAGD - 1)) ? '0 : r_rptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // An orphan beat only raises the error flag; the guard is left alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_guard <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_orphan) begin
                r_err <= 1'b1;
            end else if (app_rd_valid) begin
                r_guard <= c_GW'(GUARD);
            end else if (r_guard != '0) begin
                r_guard <= r_guard - c_GW'(1);
            end
        end
    end

    always_comb begin
        ch_ack      = '0;
        ch_wr_next  = '0;
        ch_rd_valid = '0;
        ch_rd_last  = '0;
        app_wr_data = '0;
        if ((r_state == ST_REQ) && app_req_ack) ch_ack[r_owner] = 1'b1;
        if (r_state == ST_WDATA) ch_wr_next[r_owner] = app_wr_next_req;
        if (app_rd_valid && !w_empty) begin
            ch_rd_valid[w_head] = 1'b1;
            ch_rd_last[w_head]  = app_last_rd;
        end
        if (((r_state == ST_REQ) && !r_wr_n) || (r_state == ST_WDATA)) begin
            app_wr_data = w_wdata_a[r_owner];
        end
    end

    assign app_req          = (r_state == ST_REQ);
    assign app_req_addr     = r_addr;
    assign app_req_len      = r_len;
    assign app_req_wr_n     = r_wr_n;
    assign app_req_dma_last = app_req & r_wr_n;
    assign rd_data          = app_rd_data;
    assign busy             = (r_state != ST_IDLE) || !w_empty;
    assign err_orphan_rd    = r_err;

endmodule
`default_nettype wire
